// File: rtl/acc_drain_sched.sv
// Layer sequencer and round-robin writeback arbiter for the accumulator array.
// Each column owns a 1-deep holding register; holds are drained onto one valid/ready port.
module acc_drain_sched #(
    parameter int N_COL  = 16,
    parameter int DATA_W = 8,
    parameter int COL_W  = $clog2(N_COL)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [4:0]              cmd_ofmap_size_i,
    input  logic [5:0]              cmd_ifmap_ch_i,
    output logic [4:0]              ofmap_size_o,
    output logic [5:0]              ifmap_ch_o,
    output logic                    acc_en_o,
    input  logic [N_COL-1:0]        col_valid_i,
    input  logic [N_COL-1:0]        col_last_i,
    input  logic [N_COL*DATA_W-1:0] col_data_i,
    output logic [N_COL-1:0]        col_ready_o,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [DATA_W-1:0]       wb_data_o,
    output logic [COL_W-1:0]        wb_col_o,
    output logic                    wb_last_o,
    output logic                    done_o,
    output logic                    overflow_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           ofmap_size_q;
    logic [5:0]           ifmap_ch_q;

    logic [N_COL-1:0]     hold_full_q;
    logic [N_COL-1:0]     hold_last_q;
    logic [DATA_W-1:0]    hold_data_q [N_COL];
    logic [N_COL-1:0]     last_done_q;
    logic [COL_W-1:0]     ptr_q;

    logic                 wb_valid_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic [COL_W-1:0]     wb_col_q;
    logic                 wb_last_q;
    logic                 overflow_q;

    logic                 out_load;
    logic                 grant_found;
    logic [COL_W-1:0]     grant_idx;
    logic [COL_W-1:0]     scan_idx;
    logic [N_COL-1:0]     grant_vec;
    logic [N_COL-1:0]     capture_vec;
    logic [N_COL-1:0]     ovf_vec;
    logic                 accept_cmd;
    logic                 in_run;

    assign accept_cmd = (state_q == IDLE) && cmd_valid_i;
    assign in_run     = (state_q == RUN);
    assign out_load   = ~wb_valid_q | wb_ready_i;

    // Rotating priority scan: first full hold at or after ptr_q (index wraps by width).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_COL; k++) begin
            scan_idx = ptr_q + COL_W'(k);
            if (!grant_found && hold_full_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_COL; gi++) begin : g_col
            assign grant_vec[gi]   = out_load && grant_found && (grant_idx == COL_W'(gi));
            assign capture_vec[gi] = in_run && col_valid_i[gi] && (!hold_full_q[gi] || grant_vec[gi]);
            assign ovf_vec[gi]     = in_run && col_valid_i[gi] && hold_full_q[gi] && !grant_vec[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = RUN;
            RUN:     if (&last_done_q) state_d = FLUSH;
            FLUSH:   if (out_load && !(|hold_full_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ofmap_size_q <= '0;
            ifmap_ch_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_cmd) begin
                ofmap_size_q <= cmd_ofmap_size_i;
                ifmap_ch_q   <= cmd_ifmap_ch_i;
            end
            if (|ovf_vec) overflow_q <= 1'b1;
        end
    end

    // A capture wins over the grant-clear so a beat arriving while its hold drains is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= '0;
            hold_last_q <= '0;
            last_done_q <= '0;
            for (int c = 0; c < N_COL; c++) hold_data_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_COL; c++) begin
                if (capture_vec[c]) begin
                    hold_full_q[c] <= 1'b1;
                    hold_last_q[c] <= col_last_i[c];
                    hold_data_q[c] <= col_data_i[c*DATA_W +: DATA_W];
                end else if (grant_vec[c]) begin
                    hold_full_q[c] <= 1'b0;
                end
                if (accept_cmd) begin
                    last_done_q[c] <= 1'b0;
                end else if (grant_vec[c] && hold_last_q[c]) begin
                    last_done_q[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_col_q   <= '0;
            wb_last_q  <= 1'b0;
        end else if (out_load) begin
            wb_valid_q <= grant_found;
            if (grant_found) begin
                wb_data_q <= hold_data_q[grant_idx];
                wb_col_q  <= grant_idx;
                wb_last_q <= hold_last_q[grant_idx];
                ptr_q     <= grant_idx + 1'b1;
            end
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign acc_en_o     = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign ofmap_size_o = ofmap_size_q;
    assign ifmap_ch_o   = ifmap_ch_q;
    assign col_ready_o  = ~hold_full_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_data_o    = wb_data_q;
    assign wb_col_o     = wb_col_q;
    assign wb_last_o    = wb_last_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_acc_drain_sched.sv
// Self-checking bench for acc_drain_sched: per-cycle comparison against a behavioural
// model of the layer/drain rules, plus directed literal checks on key scenarios.
module tb_acc_drain_sched;

    localparam int NC = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [4:0]      cmd_size;
    logic [5:0]      cmd_ch;
    logic [4:0]      ofmap_size;
    logic [5:0]      ifmap_ch;
    logic            acc_en;
    logic [NC-1:0]   col_valid;
    logic [NC-1:0]   col_last;
    logic [NC*DW-1:0] col_data;
    logic [NC-1:0]   col_ready;
    logic            wb_valid;
    logic            wb_ready;
    logic [DW-1:0]   wb_data;
    logic [3:0]      wb_col;
    logic            wb_last;
    logic            done;
    logic            overflow;

    acc_drain_sched #(.N_COL(NC), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ofmap_size_i(cmd_size), .cmd_ifmap_ch_i(cmd_ch),
        .ofmap_size_o(ofmap_size), .ifmap_ch_o(ifmap_ch), .acc_en_o(acc_en),
        .col_valid_i(col_valid), .col_last_i(col_last), .col_data_i(col_data),
        .col_ready_o(col_ready),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
        .wb_col_o(wb_col), .wb_last_o(wb_last),
        .done_o(done), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 run, 2 flush, 3 done.
    int          m_phase;
    logic [4:0]  m_size;
    logic [5:0]  m_ch;
    bit          m_pend [NC];
    logic [7:0]  m_pdata [NC];
    bit          m_plast [NC];
    bit          m_fin [NC];
    int          m_ptr;
    bit          m_ovf;
    bit          m_wbv;
    logic [7:0]  m_wbd;
    int          m_wbc;
    bit          m_wbl;

    always @(posedge clk) begin : model
        int  g;
        int  old_phase;
        bit  take;
        bit  pend_old [NC];
        bit  all_fin;
        bit  any_pend;
        if (rst) begin
            m_phase = 0; m_size = 0; m_ch = 0; m_ptr = 0; m_ovf = 0;
            m_wbv = 0; m_wbd = 0; m_wbc = 0; m_wbl = 0;
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = 0; m_pdata[c] = 0; m_plast[c] = 0; m_fin[c] = 0;
            end
        end else begin
            old_phase = m_phase;
            pend_old  = m_pend;
            all_fin   = 1;
            any_pend  = 0;
            for (int c = 0; c < NC; c++) begin
                all_fin  = all_fin & m_fin[c];
                any_pend = any_pend | pend_old[c];
            end
            take = !m_wbv || wb_ready;
            g = -1;
            if (take)
                for (int k = 0; k < NC; k++)
                    if (g < 0 && pend_old[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            case (old_phase)
                0: if (cmd_valid) begin
                       m_phase = 1; m_size = cmd_size; m_ch = cmd_ch;
                       for (int c = 0; c < NC; c++) m_fin[c] = 0;
                   end
                1: if (all_fin) m_phase = 2;
                2: if (take && !any_pend) m_phase = 3;
                default: m_phase = 0;
            endcase
            if (g >= 0) begin
                m_wbv = 1; m_wbd = m_pdata[g]; m_wbc = g; m_wbl = m_plast[g];
                m_pend[g] = 0;
                if (m_plast[g]) m_fin[g] = 1;
                m_ptr = (g + 1) % NC;
            end else if (take) begin
                m_wbv = 0;
            end
            if (old_phase == 1)
                for (int c = 0; c < NC; c++)
                    if (col_valid[c]) begin
                        if (!pend_old[c] || g == c) begin
                            m_pend[c] = 1; m_pdata[c] = col_data[c*DW +: DW]; m_plast[c] = col_last[c];
                        end else begin
                            m_ovf = 1;
                        end
                    end
        end
    end

    // Handshake log and done tracking
    int         hs_col [$];
    logic [7:0] hs_data [$];
    bit         hs_last [$];
    int         done_cnt = 0;
    int         hs_at_done = -1;
    bit         cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] exp_cr;
            for (int c = 0; c < NC; c++) exp_cr[c] = !m_pend[c];
            chk("cmd_ready", cmd_ready, (m_phase == 0));
            chk("acc_en", acc_en, (m_phase == 1));
            chk("done", done, (m_phase == 3));
            chk("ofmap_size", ofmap_size, m_size);
            chk("ifmap_ch", ifmap_ch, m_ch);
            chk("col_ready", col_ready, exp_cr);
            chk("overflow", overflow, m_ovf);
            chk("wb_valid", wb_valid, m_wbv);
            if (m_wbv) begin
                chk("wb_data", wb_data, m_wbd);
                chk("wb_col", wb_col, m_wbc[3:0]);
                chk("wb_last", wb_last, m_wbl);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            hs_at_done = hs_col.size();
        end
        if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
            hs_col.push_back(int'(wb_col));
            hs_data.push_back(wb_data);
            hs_last.push_back(wb_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        hs_col.delete(); hs_data.delete(); hs_last.delete();
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int cyc = 0;
        while (hs_col.size() < n && cyc < budget) begin tick(); cyc++; end
        chk(name, (hs_col.size() >= n), 1);
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int cyc = 0;
        while (done_cnt == prev && cyc < budget) begin tick(); cyc++; end
        chk(name, done_cnt, prev + 1);
    endtask

    task automatic send_cmd(input logic [4:0] s, input logic [5:0] ch);
        cmd_valid = 1; cmd_size = s; cmd_ch = ch;
        tick();
        cmd_valid = 0;
    endtask

    task automatic set_col(input int c, input logic [7:0] d, input bit last);
        col_valid[c] = 1; col_last[c] = last; col_data[c*DW +: DW] = d;
    endtask

    task automatic clear_cols();
        col_valid = '0; col_last = '0;
    endtask

    initial begin
        int d0;
        int cnt_a1, cnt_b2, cnt_last, cyc;
        int rem [NC];
        rst = 1; cmd_valid = 0; cmd_size = 0; cmd_ch = 0;
        col_valid = '0; col_last = '0; col_data = '0; wb_ready = 0;
        tick(); tick();
        rst = 0;
        cmp_en = 1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_col_ready", col_ready, 32'h0000_FFFF);
        tick();

        // Layer 1: command latch and round-robin order
        send_cmd(5'd5, 6'd3);
        chk("cfg_size", ofmap_size, 5);
        chk("cfg_ch", ifmap_ch, 3);
        chk("cfg_acc_en", acc_en, 1);
        chk("cfg_cmd_ready", cmd_ready, 0);
        wb_ready = 1;
        clear_log();
        for (int c = 0; c < NC; c++) set_col(c, 8'(c), 0);
        tick();
        clear_cols();
        chk("lat_no_wb_yet", wb_valid, 0);
        tick();
        chk("lat_wb_valid", wb_valid, 1);
        chk("lat_wb_col", wb_col, 0);
        wait_hs(16, 60, "rr0_timeout");
        for (int i = 0; i < 16 && i < hs_col.size(); i++) chk("rr0_order", hs_col[i], i);
        clear_log();
        for (int c = 0; c < 5; c++) set_col(c, 8'(8'h40 + c), 0);
        tick();
        clear_cols();
        wait_hs(5, 40, "rr_pre_timeout");
        tick(); tick();
        clear_log();
        d0 = done_cnt;
        for (int c = 0; c < NC; c++) set_col(c, 8'(8'h80 + c), 1);
        tick();
        clear_cols();
        wait_hs(16, 60, "rr5_timeout");
        for (int i = 0; i < 16 && i < hs_col.size(); i++) chk("rr5_order", hs_col[i], (5 + i) % 16);
        wait_done(d0, 40, "layer1_done");
        tick();
        chk("layer1_idle", cmd_ready, 1);

        // Layer 2: simultaneous capture/grant, then overflow under backpressure
        send_cmd(5'd9, 6'd17);
        clear_log();
        set_col(0, 8'h11, 0); tick();
        set_col(0, 8'h22, 0); tick();
        clear_cols();
        wait_hs(2, 40, "sim_timeout");
        chk("sim_no_ovf", overflow, 0);
        if (hs_data.size() >= 2) begin
            chk("sim_first", hs_data[0], 8'h11);
            chk("sim_second", hs_data[1], 8'h22);
        end
        tick(); tick();
        wb_ready = 0;
        clear_log();
        set_col(0, 8'h55, 0); tick();
        clear_cols(); tick(); tick();
        set_col(2, 8'hA1, 0); tick();
        set_col(2, 8'hB2, 0); tick();
        clear_cols(); tick();
        chk("ovf_set", overflow, 1);
        wb_ready = 1;
        wait_hs(2, 40, "ovf_drain_timeout");
        repeat (6) tick();
        cnt_a1 = 0; cnt_b2 = 0;
        foreach (hs_data[i]) begin
            if (hs_data[i] == 8'hA1) cnt_a1++;
            if (hs_data[i] == 8'hB2) cnt_b2++;
        end
        chk("ovf_a1_once", cnt_a1, 1);
        chk("ovf_b2_never", cnt_b2, 0);
        d0 = done_cnt;
        for (int c = 0; c < NC; c++) set_col(c, 8'(c * 3), 1);
        tick();
        clear_cols();
        wait_done(d0, 60, "layer2_done");
        tick();

        // Layer 3: random completion, 4 results per column, random backpressure
        send_cmd(5'($urandom_range(1, 31)), 6'($urandom_range(1, 63)));
        clear_log();
        d0 = done_cnt;
        hs_at_done = -1;
        for (int c = 0; c < NC; c++) rem[c] = 4;
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            wb_ready = $urandom_range(0, 1);
            clear_cols();
            for (int c = 0; c < NC; c++)
                if (rem[c] > 0 && col_ready[c] && $urandom_range(0, 1) == 1) begin
                    set_col(c, 8'($urandom), (rem[c] == 1));
                    rem[c]--;
                end
            tick();
            cyc++;
        end
        clear_cols();
        chk("rand_done", done_cnt, d0 + 1);
        chk("rand_words", hs_col.size(), 64);
        cnt_last = 0;
        foreach (hs_last[i]) if (hs_last[i]) cnt_last++;
        chk("rand_lasts", cnt_last, 16);
        chk("rand_done_after_64", hs_at_done, 64);
        wb_ready = 1;
        repeat (3) tick();
        chk("rand_single_done", done_cnt, d0 + 1);

        // Layer 4: reset mid-RUN with holds 3 and 7 full and output valid
        send_cmd(5'd2, 6'd4);
        wb_ready = 0;
        set_col(0, 8'h55, 0); tick();
        clear_cols(); tick(); tick();
        set_col(3, 8'h33, 0); set_col(7, 8'h77, 1); tick();
        clear_cols(); tick();
        chk("pre_rst_col_ready", col_ready, 32'h0000_FF77);
        chk("pre_rst_wb_valid", wb_valid, 1);
        rst = 1; tick(); rst = 0;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_col_ready", col_ready, 32'h0000_FFFF);
        chk("post_rst_wb_valid", wb_valid, 0);
        chk("post_rst_acc_en", acc_en, 0);
        chk("post_rst_overflow", overflow, 0);
        chk("post_rst_size", ofmap_size, 0);
        chk("post_rst_ch", ifmap_ch, 0);
        chk("post_rst_done", done, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_drain_sched.md
Name: acc_drain_sched

Overview:
Layer sequencer and writeback arbiter for the 16-column accumulator array. It accepts one layer command, then holds ofmap size and input-channel count stable to all accumulators and enables the array feed. It captures each column's conv result into a 1-deep holding register and drains the 16 columns round-robin onto a single valid/ready writeback port toward activation. It signals layer completion once every column's last result has left through writeback.

Parameters:
N_COL, 16, number of accumulator columns (power of 2)
DATA_W, 8, conv result width
COL_W, $clog2(N_COL), column index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_valid_i  input  1  layer command valid
cmd_ready_o  output  1  command accepted when high (IDLE only)
cmd_ofmap_size_i  input  5  ofmap side length
cmd_ifmap_ch_i  input  6  input channel count
ofmap_size_o  output  5  latched config to accumulators
ifmap_ch_o  output  6  latched config to accumulators
acc_en_o  output  1  enables systolic/accumulator feed
col_valid_i  input  N_COL  per-column conv_valid
col_last_i  input  N_COL  per-column conv_last
col_data_i  input  N_COL*DATA_W  per-column conv_result, column c at [c*DATA_W +: DATA_W]
col_ready_o  output  N_COL  holding register c empty
wb_valid_o  output  1  writeback data valid
wb_ready_i  input  1  writeback sink ready
wb_data_o  output  DATA_W  writeback data
wb_col_o  output  COL_W  source column of wb_data_o
wb_last_o  output  1  data is that column's last result
done_o  output  1  one-cycle layer-complete pulse
overflow_o  output  1  sticky: result arrived at a full holding register

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over everything, including mid-layer. Resulting state: IDLE; config outputs 0; acc_en_o, wb_valid_o, done_o, overflow_o 0; all holds and last_done flags cleared; RR pointer 0. cmd_ready_o then reads 1 (IDLE) and col_ready_o reads all-ones.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch config and go to RUN; acc_en_o=1 from the next cycle.
  - RUN: when the last_done flag is set for all N_COL columns, go to FLUSH.
  - FLUSH: acc_en_o=0; wait for wb_valid_o=0, or for the handshake of the final word. Then go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE. Config outputs hold their values until the next command.
- Capture: in RUN only, col_valid_i[c] with hold c empty, or hold c being granted this cycle, loads data and last into hold c on the next edge. col_valid_i in IDLE, FLUSH or DONE is ignored.
- Overflow: col_valid_i[c] with hold c full and not granted this cycle sets overflow_o (sticky until rst). The new beat is dropped and the held beat is kept.
- Output register: loads when wb_valid_o=0 or wb_ready_i=1.
  - Grant goes to the first full hold at index >= ptr, wrapping modulo N_COL.
  - On grant g: hold g clears, ptr <= (g+1) mod N_COL, wb_col_o=g. If the held last=1, last_done[g] is set.
  - With no full hold, a load empties the output register (wb_valid_o=0).
- wb_data_o, wb_col_o and wb_last_o stay stable while wb_valid_o=1 and wb_ready_i=0.
- Latency: col_valid_i at edge t gives hold full after t. Earliest wb_valid_o is after edge t+1 (2 cycles), with wb_ready_i high and no competitor.
- Throughput: 1 word/cycle while wb_ready_i=1.
- col_ready_o[c] = ~hold_full[c] (combinational from registers). Upstream uses it for stall/diagnostic only.

Test Plan:
- Reset mid-RUN: with holds 3 and 7 full and wb_valid_o=1, assert rst one cycle -> next cycle all outputs at reset values, cmd_ready_o=1, col_ready_o=16'hFFFF.
- Command: cmd_valid_i with size=5, ch=3 in IDLE -> ofmap_size_o=5, ifmap_ch_o=3, acc_en_o=1 next cycle; cmd_ready_o=0 until after done_o.
- Round-robin: all 16 col_valid_i in one cycle with data=c, wb_ready_i=1 -> wb_col_o sequence 0..15, one per cycle, first wb_valid_o 2 cycles after input. Repeat with ptr=5 -> order 5..15, 0..4.
- Backpressure/overflow: wb_ready_i=0, col 2 valid (data 0xA1) then valid again (0xB2) -> overflow_o=1. After releasing wb_ready_i, 0xA1 appears once and 0xB2 never.
- Completion: each column sends 4 results, last on the 4th, wb_ready_i toggled 50% -> 64 words out. Exactly 16 words carry wb_last_o=1. done_o pulses once, only after the 64th handshake, and acc_en_o=0 in FLUSH and DONE.
- Simultaneous capture and grant: col 0 hold full and granted in the same cycle col_valid_i[0]=1 -> no overflow, new beat held and output next grant.
